square_arbiter: RTL
===================

SQUARE_ARBITER -- requirements
Module: square_arbiter

Interface
REQ-001 SHALL run on one clock; reset is asynchronous and active-low.
REQ-002 Parameters SHALL be: N_REQ, 4, number of requesters; WIDTH, 16, operand/result width; TIMEOUT, 15, max cycles in ISSUE+WAIT before abort (>=4).
REQ-003 Ports SHALL be:
- clk_in  input  1  clock.
- rst_n_in  input  1  async active-low reset.
- req_in  input  N_REQ  per-requester level request.
- value_in  input  N_REQ*WIDTH  packed operands; requester i at bits [i*WIDTH +: WIDTH].
- grant_out  output  N_REQ  one-hot, current owner.
- done_out  output  N_REQ  one-hot, 1-cycle completion pulse.
- result_out  output  WIDTH  result for the done_out requester.
- error_out  output  1  1-cycle timeout flag, coincident with done_out.
- busy_out  output  1  high whenever state != IDLE.
- sq_ready_out  output  1  start strobe to square unit.
- sq_value_out  output  WIDTH  operand to square unit.
- sq_busy_in  input  1  square unit busy.
- sq_valid_in  input  1  square unit result valid.
- sq_result_in  input  WIDTH  square unit result.

Function
REQ-004 FSM SHALL have states IDLE, ISSUE, WAIT, DONE; all outputs registered except busy_out (decoded from state).
REQ-005 IDLE: if any req_in bit high, SHALL select the winner by round-robin starting at pointer ptr, latch winner index and its value_in slice, set grant_out one-hot, go ISSUE; else stay IDLE.
REQ-006 Round-robin: ptr SHALL become (winner+1) mod N_REQ on leaving DONE; ptr wraps N_REQ-1 -> 0.
REQ-007 ISSUE: sq_ready_out SHALL be 1 only in ISSUE cycles where sq_busy_in=0; after a cycle with sq_ready_out=1 the FSM SHALL go WAIT; while sq_busy_in=1 it SHALL stay in ISSUE with sq_ready_out=0.
REQ-008 sq_value_out SHALL equal the latched operand from ISSUE entry through DONE (square unit samples it one cycle after the strobe); 0 in IDLE.
REQ-009 WAIT: on sq_valid_in=1, SHALL latch sq_result_in into result_out and go DONE.
REQ-010 A cycle counter SHALL clear on ISSUE entry and increment each ISSUE/WAIT cycle; on reaching TIMEOUT without sq_valid_in, SHALL set result_out=0, assert error_out, go DONE.
REQ-011 DONE: lasts exactly 1 cycle; done_out[winner]=1 (and error_out if timed out); then grant_out cleared, state IDLE.
REQ-012 Nominal latency: req sampled at edge 0 -> sq_ready_out high cycle 1 -> sq_valid_in cycle 3 -> done_out cycle 4 -> IDLE cycle 5; max throughput one operation per 5 cycles.
REQ-013 Once latched, an operation SHALL complete even if req_in[winner] or value_in change; requesters hold req_in until done_out and drop it in the done cycle to avoid re-grant.
REQ-014 sq_valid_in outside WAIT SHALL be ignored; sq_valid_in and timeout in the same cycle SHALL take the valid result (error_out=0).
REQ-015 result_out SHALL hold its value until the next DONE; no width extension or truncation beyond sq_result_in.

Reset
REQ-016 rst_n_in=0 SHALL asynchronously force state IDLE, ptr=0, counter=0, grant_out=0, done_out=0, result_out=0, error_out=0, sq_ready_out=0, sq_value_out=0.
REQ-017 Reset mid-operation SHALL abort without done_out; a late sq_valid_in after reset release SHALL be ignored (IDLE).

Verification
REQ-018 Single request: req_in=0001, value 3 -> sq_ready_out cycle 1, sq_value_out=3, done_out=0001 cycle 4, result_out=9.
REQ-019 All four requesting, values 1,2,3,4 held -> grants order 0,1,2,3,0; results 1,4,9,16; each done 5 cycles apart.
REQ-020 Wrap: only req 3 and 0, ptr=3 -> grant 3 first then 0; value 0x0100 -> result_out=0x0000 (16-bit truncation).
REQ-021 sq_valid_in never asserted -> error_out and done_out pulse after TIMEOUT cycles, result_out=0, next requester granted.
REQ-022 sq_busy_in held high 3 cycles in ISSUE -> sq_ready_out stays 0 until busy low, then single 1-cycle strobe.
REQ-023 rst_n_in low during WAIT -> all outputs 0 immediately, no done_out; subsequent request served from ptr=0.

Source files
------------

// File: rtl/square_arbiter.sv
`timescale 1ns/1ps
// Round-robin arbiter that shares one external square unit among N_REQ requesters.
// Each grant issues one operand, waits for the result (bounded by TIMEOUT),
// and returns it to the winner with a one-cycle done pulse.
module square_arbiter #(
  parameter int unsigned N_REQ   = 4,
  parameter int unsigned WIDTH   = 16,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic                   clk_in,
  input  logic                   rst_n_in,
  input  logic [N_REQ-1:0]       req_in,
  input  logic [N_REQ*WIDTH-1:0] value_in,
  output logic [N_REQ-1:0]       grant_out,
  output logic [N_REQ-1:0]       done_out,
  output logic [WIDTH-1:0]       result_out,
  output logic                   error_out,
  output logic                   busy_out,
  output logic                   sq_ready_out,
  output logic [WIDTH-1:0]       sq_value_out,
  input  logic                   sq_busy_in,
  input  logic                   sq_valid_in,
  input  logic [WIDTH-1:0]       sq_result_in
);

  localparam int unsigned IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_REQ - 1);
  // Counter value in the final allowed ISSUE/WAIT cycle
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

  state_t           state;
  logic [IDX_W-1:0] ptr;
  logic [IDX_W-1:0] winner;
  logic [CNT_W-1:0] cnt;
  logic [IDX_W-1:0] rr_idx;
  logic             rr_found;
  int unsigned      cand;

  // Busy is a pure decode of the state
  assign busy_out = (state != S_IDLE);

  // First active requester at or after ptr, wrapping at N_REQ
  always_comb begin
    rr_idx   = ptr;
    rr_found = 1'b0;
    cand     = 0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      cand = 32'(ptr) + i;
      if (cand >= N_REQ) cand = cand - N_REQ;
      if (!rr_found && req_in[IDX_W'(cand)]) begin
        rr_found = 1'b1;
        rr_idx   = IDX_W'(cand);
      end
    end
  end

  // Arbitration FSM with registered handshake and result outputs
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state        <= S_IDLE;
      ptr          <= '0;
      winner       <= '0;
      cnt          <= '0;
      grant_out    <= '0;
      done_out     <= '0;
      result_out   <= '0;
      error_out    <= 1'b0;
      sq_ready_out <= 1'b0;
      sq_value_out <= '0;
    end else begin
      done_out     <= '0;
      error_out    <= 1'b0;
      sq_ready_out <= 1'b0;
      case (state)
        S_IDLE: begin
          if (rr_found) begin
            winner       <= rr_idx;
            grant_out    <= N_REQ'(1) << rr_idx;
            sq_value_out <= value_in[32'(rr_idx)*WIDTH +: WIDTH];
            cnt          <= '0;
            sq_ready_out <= !sq_busy_in;
            state        <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (cnt == CNT_LAST) begin
            result_out <= '0;
            error_out  <= 1'b1;
            done_out   <= grant_out;
            state      <= S_DONE;
          end else begin
            cnt <= cnt + 1'b1;
            if (sq_ready_out) state <= S_WAIT;
            else              sq_ready_out <= !sq_busy_in;
          end
        end
        S_WAIT: begin
          // A valid result wins over a coincident timeout
          if (sq_valid_in) begin
            result_out <= sq_result_in;
            done_out   <= grant_out;
            state      <= S_DONE;
          end else if (cnt == CNT_LAST) begin
            result_out <= '0;
            error_out  <= 1'b1;
            done_out   <= grant_out;
            state      <= S_DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_DONE: begin
          grant_out    <= '0;
          sq_value_out <= '0;
          ptr          <= (winner == LAST_IDX) ? '0 : winner + 1'b1;
          state        <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
